// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the mux scan sequencer: FSM state encoding, channel
// count, select width and the default sample width.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int N_CH           = 4;
    localparam int SEL_W          = 2;
    localparam int DEFAULT_DATA_W = 2;

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
// Counts the cycles spent on one mux channel. The counter runs from 0 to
// DWELL-1 while enabled and clears itself after reaching DWELL-1, so it never
// wraps.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - force the count back to zero (highest priority after reset)
//   en   - advance the count this cycle
//   last - count is at DWELL-1 (end of the current dwell)
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Drives the select of a 4:1 mux, dwells DWELL cycles on each channel,
// samples the mux output at the end of each dwell into shadow slots and
// publishes all four slots at once as snap_data, with a one-cycle done pulse.
// Supports one-shot and continuous scanning, plus abort.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - begin a scan (only honoured in IDLE)
//   cont       - rescan immediately after a snapshot when high
//   stop       - abort to IDLE from any state
//   y          - mux output for the current sel
//   sel        - mux select
//   busy       - scan in progress (SCAN or DONE)
//   done       - snapshot published this cycle
//   snap_data  - last published snapshot, slot k at [k*DATA_W +: DATA_W]
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DWELL  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     stop,
    input  logic [DATA_W-1:0]        y,
    output logic [SEL_W-1:0]         sel,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH*DATA_W-1:0]   snap_data
);

    scan_state_t              state_q;
    scan_state_t              state_d;
    logic [SEL_W-1:0]         sel_q;
    logic [SEL_W-1:0]         sel_d;
    logic [DATA_W-1:0]        shadow_q [N_CH];
    logic [DATA_W-1:0]        shadow_d [N_CH];
    logic [N_CH*DATA_W-1:0]   snap_q;
    logic [N_CH*DATA_W-1:0]   snap_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;
    logic capture;
    logic publish;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    // The counter only runs in SCAN; everywhere else (and on abort) it is
    // held at zero so every scan starts with a full dwell on channel 0.
    assign cnt_en  = (state_q == SCAN);
    assign cnt_clr = (state_q != SCAN) || stop;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cnt_last) begin
                    capture = 1'b1;
                    if (sel_q == SEL_W'(N_CH - 1)) begin
                        state_d = DONE;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                sel_d   = '0;
                state_d = cont ? SCAN : IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
        // Abort wins over everything except reset and discards the capture.
        if (stop) begin
            state_d = IDLE;
            sel_d   = '0;
            capture = 1'b0;
        end
    end

    // Publishing happens on the edge that captures the last channel, so the
    // snapshot is already valid during the DONE cycle. shadow_d carries the
    // final channel's fresh sample, keeping the snapshot coherent.
    assign publish = capture && (sel_q == SEL_W'(N_CH - 1));

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
            assign shadow_d[gi] = (capture && (sel_q == SEL_W'(gi))) ? y : shadow_q[gi];
            assign snap_d[gi*DATA_W +: DATA_W] =
                publish ? shadow_d[gi] : snap_q[gi*DATA_W +: DATA_W];

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q[gi] <= '0;
                end else begin
                    shadow_q[gi] <= shadow_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign snap_data = snap_q;

endmodule
